// File: rtl/fifo_shift_reg_sync.sv
// fifo_shift_reg_sync: shift-register FIFO with the head word always in slot 0.
// Define FIFO_FWFT_EN for first-word-fall-through output; the default build registers dataOut.
module fifo_shift_reg_sync #(
  parameter  int unsigned FIFO_width = 32,
  parameter  int unsigned FIFO_depth = 10,
  parameter  int unsigned AF_thresh  = 8,
  parameter  int unsigned AE_thresh  = 2,
  localparam int unsigned CW         = $clog2(FIFO_depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  writeEnable,
  input  logic [FIFO_width-1:0] dataIn,
  input  logic                  readEnable,
  input  logic                  clearErr,
  output logic [FIFO_width-1:0] dataOut,
  output logic                  dataValid,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almostEmpty,
  output logic                  almostFull,
  output logic                  overflow,
  output logic                  underflow
);

  logic [FIFO_width-1:0] slot     [FIFO_depth];
  logic [FIFO_width-1:0] slot_nxt [FIFO_depth];
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         wr_idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_nxt;
  logic                  unf_nxt;

  assign empty       = (count == '0);
  assign full        = (count == CW'(FIFO_depth));
  assign almostFull  = (count >= CW'(AF_thresh));
  assign almostEmpty = (count <= CW'(AE_thresh));

  assign rd_acc = readEnable & ~empty;
  assign wr_acc = writeEnable & (~full | rd_acc);
  // On a simultaneous read the shift frees slot[count-1], so the write lands there.
  assign wr_idx = rd_acc ? count - CW'(1) : count;

  always_comb begin
    slot_nxt  = slot;
    count_nxt = count;
    ovf_nxt   = overflow & ~clearErr;
    unf_nxt   = underflow & ~clearErr;
    if (flush) begin
      for (int unsigned i = 0; i < FIFO_depth; i++) slot_nxt[i] = '0;
      count_nxt = '0;
    end else begin
      if (rd_acc) begin
        for (int unsigned i = 0; i + 1 < FIFO_depth; i++) slot_nxt[i] = slot[i + 1];
        slot_nxt[FIFO_depth-1] = '0;
      end
      if (wr_acc) begin
        for (int unsigned i = 0; i < FIFO_depth; i++)
          if (CW'(i) == wr_idx) slot_nxt[i] = dataIn;
      end
      case ({rd_acc, wr_acc})
        2'b10:   count_nxt = count - CW'(1);
        2'b01:   count_nxt = count + CW'(1);
        default: count_nxt = count;
      endcase
      ovf_nxt = ovf_nxt | (writeEnable & ~wr_acc);
      unf_nxt = unf_nxt | (readEnable & empty);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_depth; i++) slot[i] <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (enable) begin
      for (int unsigned i = 0; i < FIFO_depth; i++) slot[i] <= slot_nxt[i];
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

`ifdef FIFO_FWFT_EN
  assign dataOut   = slot[0];
  assign dataValid = ~empty;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        dataValid <= 1'b0;
      end else if (rd_acc) begin
        dataOut   <= slot[0];
        dataValid <= 1'b1;
      end else begin
        dataValid <= 1'b0;
      end
    end
  end
`endif

endmodule
